// File: rtl/record_framer_pkg.sv
// Shared types and helpers for the record framer: FSM encoding, field widths
// and the header word layout.
package record_framer_pkg;

   localparam int WORD_W = 16;
   localparam int LEN_W  = 8;
   localparam int SEQ_W  = 4;
   localparam int TAG_W  = 4;

   localparam logic [TAG_W-1:0] HDR_TAG_DEFAULT = 4'hA;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2,
      ST_CSUM = 2'd3
   } framer_state_t;

   // Header word: tag in the top nibble, sequence number, then payload length.
   function automatic logic [WORD_W-1:0] make_header(
      input logic [TAG_W-1:0] tag,
      input logic [SEQ_W-1:0] seq,
      input logic [LEN_W-1:0] len
   );
      return {tag, seq, len};
   endfunction

   // Running payload checksum: plain 16-bit wrapping sum.
   function automatic logic [WORD_W-1:0] csum_add(
      input logic [WORD_W-1:0] acc,
      input logic [WORD_W-1:0] word
   );
      return acc + word;
   endfunction

endpackage

// File: rtl/record_ring_buffer.sv
// DEPTH x 16 record ring with combinational read. A push into a full ring is
// refused even when a pop happens in the same cycle.
module record_ring_buffer
   import record_framer_pkg::*;
#(
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [WORD_W-1:0] wr_data,
   output logic [WORD_W-1:0] rd_data,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [AW-1:0] STEP_C  = AW'(1);

   logic [WORD_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic              push_ok_s;
   logic              pop_ok_s;

   assign full      = (count_r == DEPTH_C);
   assign empty     = (count_r == {CW{1'b0}});
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign rd_data   = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Storage array, no reset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (clr) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + STEP_C;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + STEP_C;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + ONE_C;
            2'b01:   count_r <= count_r - ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/record_framer.sv
// Buffers result records and emits them as header / payload / checksum frames
// into the output FIFO, with flush support for a short final frame.
module record_framer
   import record_framer_pkg::*;
#(
   parameter int               FRAME_LEN = 64,
   parameter int               DEPTH     = 256,
   parameter logic [TAG_W-1:0] HDR_TAG   = HDR_TAG_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   input  logic              flush,
   input  logic              out_full,
   output logic              out_wr_en,
   output logic [WORD_W-1:0] out_data,
   output logic              busy,
   output logic              overflow,
   output logic [15:0]       frame_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]    FRAME_LEN_C = CW'(FRAME_LEN);
   localparam logic [LEN_W-1:0] FRAME_LEN_L = LEN_W'(FRAME_LEN);

   framer_state_t     state_r;
   framer_state_t     state_next_s;

   logic [CW-1:0]     count_s;
   logic              full_s;
   logic              empty_s;
   logic [WORD_W-1:0] rd_data_s;

   logic              start_s;
   logic              issue_s;
   logic              pop_s;
   logic [WORD_W-1:0] word_s;
   logic [LEN_W-1:0]  len_start_s;

   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  rem_r;
   logic [WORD_W-1:0] csum_r;
   logic [SEQ_W-1:0]  seq_r;
   logic              flush_pend_r;
   logic              out_wr_en_r;
   logic [WORD_W-1:0] out_data_r;
   logic [15:0]       frame_count_r;
   logic              overflow_r;

   record_ring_buffer #(
      .DEPTH (DEPTH)
   ) u_ring (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .push    (in_valid),
      .pop     (pop_s),
      .wr_data (in_data),
      .rd_data (rd_data_s),
      .count   (count_s),
      .full    (full_s),
      .empty   (empty_s)
   );

   // A frame carries at most FRAME_LEN words; a flush takes whatever is left.
   assign len_start_s = (count_s >= FRAME_LEN_C) ? FRAME_LEN_L : LEN_W'(count_s);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else if (clr) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; every emitting state holds while the FIFO is full.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) state_next_s = ST_HDR;
            else         state_next_s = ST_IDLE;
         end
         ST_HDR: begin
            if (!out_full) state_next_s = ST_PAY;
            else           state_next_s = ST_HDR;
         end
         ST_PAY: begin
            if (!out_full && (rem_r == 8'd1)) state_next_s = ST_CSUM;
            else                              state_next_s = ST_PAY;
         end
         ST_CSUM: begin
            if (!out_full) state_next_s = ST_IDLE;
            else           state_next_s = ST_CSUM;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM outputs: frame start, word issue, ring pop and the word to write.
   always_comb begin
      start_s = 1'b0;
      issue_s = 1'b0;
      pop_s   = 1'b0;
      word_s  = {WORD_W{1'b0}};
      case (state_r)
         ST_IDLE: begin
            start_s = (count_s >= FRAME_LEN_C) || (flush_pend_r && !empty_s);
         end
         ST_HDR: begin
            issue_s = !out_full;
            word_s  = make_header(HDR_TAG, seq_r, len_r);
         end
         ST_PAY: begin
            issue_s = !out_full;
            pop_s   = !out_full;
            word_s  = rd_data_s;
         end
         ST_CSUM: begin
            issue_s = !out_full;
            word_s  = csum_r;
         end
         default: begin
            start_s = 1'b0;
            issue_s = 1'b0;
            pop_s   = 1'b0;
            word_s  = {WORD_W{1'b0}};
         end
      endcase
   end

   // Frame datapath, status flags and the registered FIFO write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_r         <= {LEN_W{1'b0}};
         rem_r         <= {LEN_W{1'b0}};
         csum_r        <= {WORD_W{1'b0}};
         seq_r         <= {SEQ_W{1'b0}};
         flush_pend_r  <= 1'b0;
         out_wr_en_r   <= 1'b0;
         out_data_r    <= {WORD_W{1'b0}};
         frame_count_r <= 16'd0;
         overflow_r    <= 1'b0;
      end else if (clr) begin
         len_r         <= {LEN_W{1'b0}};
         rem_r         <= {LEN_W{1'b0}};
         csum_r        <= {WORD_W{1'b0}};
         seq_r         <= {SEQ_W{1'b0}};
         flush_pend_r  <= 1'b0;
         out_wr_en_r   <= 1'b0;
         out_data_r    <= {WORD_W{1'b0}};
         frame_count_r <= 16'd0;
         overflow_r    <= 1'b0;
      end else begin
         out_wr_en_r <= issue_s;
         if (issue_s) begin
            out_data_r <= word_s;
         end
         if (in_valid && full_s) begin
            overflow_r <= 1'b1;
         end
         if (start_s) begin
            len_r  <= len_start_s;
            rem_r  <= len_start_s;
            csum_r <= {WORD_W{1'b0}};
         end else if (pop_s) begin
            rem_r  <= rem_r - 8'd1;
            csum_r <= csum_add(csum_r, rd_data_s);
         end
         if (issue_s && (state_r == ST_CSUM)) begin
            seq_r         <= seq_r + 4'd1;
            frame_count_r <= frame_count_r + 16'd1;
         end
         // A new flush request wins over the clears so it is never lost.
         if (flush) begin
            flush_pend_r <= 1'b1;
         end else if ((state_r == ST_IDLE) && empty_s) begin
            flush_pend_r <= 1'b0;
         end else if (start_s && (count_s <= FRAME_LEN_C)) begin
            flush_pend_r <= 1'b0;
         end
      end
   end

   assign out_wr_en   = out_wr_en_r;
   assign out_data    = out_data_r;
   assign busy        = (state_r != ST_IDLE);
   assign overflow    = overflow_r;
   assign frame_count = frame_count_r;

endmodule

// File: tb/tb_record_framer.sv
// Scoreboard bench for record_framer: expected frames are queued as stimulus
// is driven and compared word by word as the FIFO write port fires.
module tb_record_framer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'd0;
   logic        flush = 1'b0;
   logic        out_full = 1'b0;
   logic        out_wr_en;
   logic [15:0] out_data;
   logic        busy;
   logic        overflow;
   logic [15:0] frame_count;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] sb [$];
   logic [15:0] exp_w;
   bit          sb_en = 1'b1;
   logic [3:0]  exp_seq = 4'd0;

   record_framer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .flush       (flush),
      .out_full    (out_full),
      .out_wr_en   (out_wr_en),
      .out_data    (out_data),
      .busy        (busy),
      .overflow    (overflow),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Queue one complete frame: header, payload base..base+n-1, checksum.
   task automatic expect_frame(input logic [15:0] base, input int n);
      logic [15:0] sum;
      logic [15:0] w;
      sum = 16'd0;
      sb.push_back({4'hA, exp_seq, 8'(n)});
      for (int i = 0; i < n; i++) begin
         w = base + 16'(i);
         sb.push_back(w);
         sum = sum + w;
      end
      sb.push_back(sum);
      exp_seq = exp_seq + 4'd1;
   endtask

   task automatic push_words(input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = base + 16'(i);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while (((sb.size() != 0) || busy) && (cyc < 3000)) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 3000) check_val("drain_timeout", 32'(cyc), 32'd0);
   endtask

   // Compare every FIFO write against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && sb_en && out_wr_en) begin
         if (sb.size() == 0) begin
            check_val("extra_word", {16'd0, out_data}, 32'hFFFF_FFFF);
         end else begin
            exp_w = sb.pop_front();
            check_val("word", {16'd0, out_data}, {16'd0, exp_w});
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check_val("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
      check_val("rst_data", {16'd0, out_data}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_ovf", {31'd0, overflow}, 32'd0);
      check_val("rst_fc", {16'd0, frame_count}, 32'd0);
      rst_n = 1'b1;

      // Full frame 0..63 with header latency check
      expect_frame(16'd0, 64);
      push_words(16'd0, 64);
      @(negedge clk);
      check_val("lat_early", {31'd0, out_wr_en}, 32'd0);
      @(negedge clk);
      check_val("lat_hdr", {15'd0, out_wr_en, out_data}, {15'd0, 1'b1, 16'hA040});
      drain();
      check_val("fc_t1", {16'd0, frame_count}, 32'd1);

      // Short flushed frame, then a flush with nothing buffered
      expect_frame(16'd1, 5);
      push_words(16'd1, 5);
      pulse_flush();
      drain();
      repeat (2) @(negedge clk);
      check_val("busy_after_flush", {31'd0, busy}, 32'd0);
      check_val("fc_t2", {16'd0, frame_count}, 32'd2);
      pulse_flush();
      repeat (10) @(negedge clk);
      check_val("empty_flush_busy", {31'd0, busy}, 32'd0);
      check_val("empty_flush_fc", {16'd0, frame_count}, 32'd2);

      // Back-pressure mid-payload
      expect_frame(16'h0100, 64);
      push_words(16'h0100, 64);
      repeat (8) @(negedge clk);
      out_full = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("stall_quiet", {31'd0, out_wr_en}, 32'd0);
      end
      out_full = 1'b0;
      drain();
      check_val("fc_t3", {16'd0, frame_count}, 32'd3);

      // One-word frames walk seq up to 14
      for (int k = 0; k < 11; k++) begin
         expect_frame(16'h0040 + 16'(k), 1);
         push_words(16'h0040 + 16'(k), 1);
         pulse_flush();
         drain();
      end
      check_val("fc_walk", {16'd0, frame_count}, 32'd14);

      // Overfill while stalled, then four frames with seq wrapping 15 -> 0
      out_full = 1'b1;
      for (int j = 0; j < 4; j++) expect_frame(16'h1000 + 16'(64 * j), 64);
      push_words(16'h1000, 257);
      @(negedge clk);
      check_val("ovf_set", {31'd0, overflow}, 32'd1);
      out_full = 1'b0;
      drain();
      check_val("ovf_sticky", {31'd0, overflow}, 32'd1);
      check_val("fc_t4", {16'd0, frame_count}, 32'd18);

      // Asynchronous reset mid-payload
      sb_en = 1'b0;
      push_words(16'h3000, 64);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("arst_wr_en", {31'd0, out_wr_en}, 32'd0);
      check_val("arst_ovf", {31'd0, overflow}, 32'd0);
      check_val("arst_fc", {16'd0, frame_count}, 32'd0);
      check_val("arst_busy", {31'd0, busy}, 32'd0);
      exp_seq = 4'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sb_en = 1'b1;
      repeat (20) @(negedge clk);
      check_val("arst_idle", {31'd0, busy}, 32'd0);

      // Continuous input across a frame: next frame holds the new words
      expect_frame(16'h2000, 64);
      expect_frame(16'h2040, 64);
      push_words(16'h2000, 128);
      drain();
      check_val("no_drop", {31'd0, overflow}, 32'd0);
      check_val("fc_t5", {16'd0, frame_count}, 32'd2);

      // Synchronous clear mid-frame
      sb_en = 1'b0;
      push_words(16'h4000, 64);
      repeat (10) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check_val("clr_wr_en", {31'd0, out_wr_en}, 32'd0);
      check_val("clr_busy", {31'd0, busy}, 32'd0);
      check_val("clr_fc", {16'd0, frame_count}, 32'd0);
      exp_seq = 4'd0;
      sb_en = 1'b1;
      repeat (20) @(negedge clk);

      // Fresh frame after clear restarts at seq 0
      expect_frame(16'h5000, 1);
      push_words(16'h5000, 1);
      pulse_flush();
      drain();
      check_val("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
